dmem_responder: RTL

- Data-memory responder at the far end of the core's data port (mem_w_en / address / write data out, mem_r_data in).
- Serves a word-addressed RAM through a one-entry posted-write buffer with read forwarding.
- Also serves a small MMIO window: cycle counter, tohost mailbox, misalignment status.
- Read data is combinational from the address, so the core's MEM stage latches mem_r_data in the same cycle it drives the address.

---
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Data-port bus between the core's MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    modport master (
        output mem_w_en,
        output mem_addr,
        output mem_w_data,
        input  mem_r_data
    );

    modport slave (
        input  mem_w_en,
        input  mem_addr,
        input  mem_w_data,
        output mem_r_data
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a one-entry posted-write buffer with read forwarding, plus an MMIO window
// (cycle counter, tohost mailbox, misalignment status). Define DMEM_CYCLE_CNT_EN to build the cycle counter.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic [31:0] tohost_data,
    output logic        tohost_valid,
    output logic        misalign_err
);

    logic [31:0]       ram [DEPTH];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_idx;
    logic [31:0]       pend_data;

    logic              is_mmio;
    logic              aligned;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        mmio_off;
    logic              ram_wr;
    logic              mmio_wr;
    logic [31:0]       ram_rd;
    logic [31:0]       cnt_rd;

    assign is_mmio  = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
    assign aligned  = (bus.mem_addr[1:0] == 2'b00);
    assign idx      = bus.mem_addr[ADDR_W+1:2];
    assign mmio_off = bus.mem_addr[3:2];
    assign ram_wr   = bus.mem_w_en && aligned && !is_mmio;
    assign mmio_wr  = bus.mem_w_en && aligned && is_mmio;

    // The pending entry drains into the array on every edge; a reset edge drops it instead.
    always_ff @(posedge clk) begin
        if (!rst && pend_valid) begin
            ram[pend_idx] <= pend_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= ram_wr;
            if (ram_wr) begin
                pend_idx  <= idx;
                pend_data <= bus.mem_w_data;
            end
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cnt_rd = cycle_cnt;
`else
    assign cnt_rd = 32'h0000_0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_data  <= '0;
            tohost_valid <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            tohost_valid <= mmio_wr && (mmio_off == 2'd1);
            if (mmio_wr && (mmio_off == 2'd1)) begin
                tohost_data <= bus.mem_w_data;
            end
            // A misaligned write is dropped, so it can never clear the flag in the same cycle.
            if (bus.mem_w_en && !aligned) begin
                misalign_err <= 1'b1;
            end else if (mmio_wr && (mmio_off == 2'd2) && bus.mem_w_data[0]) begin
                misalign_err <= 1'b0;
            end
        end
    end

    assign ram_rd = (pend_valid && (pend_idx == idx)) ? pend_data : ram[idx];

    always_comb begin
        bus.mem_r_data = ram_rd;
        if (is_mmio) begin
            case (mmio_off)
                2'd0:    bus.mem_r_data = cnt_rd;
                2'd1:    bus.mem_r_data = tohost_data;
                2'd2:    bus.mem_r_data = {31'b0, misalign_err};
                default: bus.mem_r_data = 32'h0000_0000;
            endcase
        end
    end

endmodule
